// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button debouncer.
package btn_pkg;

    // Per-button debounce / press-qualification states.
    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        LONG_HELD,
        RELEASE_WAIT
    } btn_state_t;

    // Number of clock cycles spanning `ms` milliseconds at `clk_hz`.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_tick_gen.sv
// Millisecond tick generator: one-cycle pulse every DIV clocks.
module btn_tick_gen #(
    parameter int unsigned DIV = 27000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic tick_d, tick_q;

    generate
        if (DIV <= 1) begin : g_every
            // A divide-by-one tick is simply high on every cycle out of reset.
            assign tick_d = 1'b1;
        end else begin : g_div
            localparam int W = $clog2(DIV);
            logic [W-1:0] cnt_q, cnt_d;

            // Free-running 0..DIV-1 counter, wraps at the terminal count.
            always_comb begin
                cnt_d = cnt_q + W'(1);
                if (cnt_q == W'(DIV - 1)) cnt_d = '0;
            end

            // Counter register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) cnt_q <= '0;
                else     cnt_q <= cnt_d;
            end

            assign tick_d = (cnt_q == W'(DIV - 1));
        end
    endgenerate

    // Registered tick so every consumer sees a clean single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_q <= 1'b0;
        else     tick_q <= tick_d;
    end

    assign tick = tick_q;

endmodule

// File: rtl/btn_debounce_sv.sv
// Multi-button debouncer with press / release / long-press pulses.
module btn_debounce_sv
    import btn_pkg::*;
#(
    parameter int unsigned CLOCK_XTAL      = 27000000,
    parameter int unsigned BTN_NUM         = 2,
    parameter int unsigned DEBOUNCE_MS     = 10,
    parameter int unsigned LONG_MS         = 1000,
    parameter int unsigned BTN_ACTIVE_HIGH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BTN_NUM-1:0] btns,
    output logic [BTN_NUM-1:0] btn_level,
    output logic [BTN_NUM-1:0] btn_press,
    output logic [BTN_NUM-1:0] btn_release,
    output logic [BTN_NUM-1:0] btn_long
);

    localparam int unsigned      TICK_DIV  = ms_to_cycles(CLOCK_XTAL, 1);
    localparam int               DW        = $clog2(DEBOUNCE_MS + 1);
    localparam int               HW        = $clog2(LONG_MS + 1);
    // Raw pin value meaning "not pressed"; XOR with it normalises to pressed=1.
    localparam logic [BTN_NUM-1:0] IDLE_PINS = (BTN_ACTIVE_HIGH != 0) ? '0 : '1;

    logic [BTN_NUM-1:0] sync1_d, sync1_q, sync2_d, sync2_q;
    logic [BTN_NUM-1:0] pressed;
    logic               tick;

    // Two-flop synchronizer chain on the raw pins.
    always_comb begin
        sync1_d = btns;
        sync2_d = sync1_q;
    end

    // Synchronizer flops idle at the not-pressed level so a held button looks new after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= IDLE_PINS;
            sync2_q <= IDLE_PINS;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign pressed = sync2_q ^ IDLE_PINS;

    btn_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    generate
        for (genvar i = 0; i < int'(BTN_NUM); i++) begin : g_btn
            btn_state_t    state_d, state_q, ret_d, ret_q;
            logic [DW-1:0] deb_d, deb_q, deb_inc;
            logic [HW-1:0] hold_d, hold_q, hold_inc;
            logic          level_d, level_q, press_d, press_q;
            logic          rel_d, rel_q, long_d, long_q;

            // Saturating increments so neither counter can wrap.
            assign deb_inc  = (deb_q  == DW'(DEBOUNCE_MS)) ? deb_q  : deb_q  + DW'(1);
            assign hold_inc = (hold_q == HW'(LONG_MS))     ? hold_q : hold_q + HW'(1);

            // Next-state and pulse generation for one button.
            always_comb begin
                state_d = state_q;
                ret_d   = ret_q;
                deb_d   = deb_q;
                hold_d  = hold_q;
                level_d = level_q;
                press_d = 1'b0;
                rel_d   = 1'b0;
                long_d  = 1'b0;
                case (state_q)
                    IDLE: begin
                        if (pressed[i]) begin
                            state_d = PRESS_WAIT;
                            deb_d   = '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!pressed[i]) begin
                            state_d = IDLE;
                        end else if (tick) begin
                            deb_d = deb_inc;
                            if (deb_inc == DW'(DEBOUNCE_MS)) begin
                                state_d = PRESSED;
                                level_d = 1'b1;
                                press_d = 1'b1;
                                hold_d  = '0;
                            end
                        end
                    end
                    PRESSED: begin
                        if (!pressed[i]) begin
                            state_d = RELEASE_WAIT;
                            ret_d   = PRESSED;
                            deb_d   = '0;
                        end else if (tick) begin
                            hold_d = hold_inc;
                            if (hold_inc == HW'(LONG_MS)) begin
                                state_d = LONG_HELD;
                                long_d  = 1'b1;
                            end
                        end
                    end
                    LONG_HELD: begin
                        if (!pressed[i]) begin
                            state_d = RELEASE_WAIT;
                            ret_d   = LONG_HELD;
                            deb_d   = '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        // A release glitch resumes where it left off; hold time is kept.
                        if (pressed[i]) begin
                            state_d = ret_q;
                        end else if (tick) begin
                            deb_d = deb_inc;
                            if (deb_inc == DW'(DEBOUNCE_MS)) begin
                                state_d = IDLE;
                                level_d = 1'b0;
                                rel_d   = 1'b1;
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end

            // Per-button state, counters and registered outputs.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= IDLE;
                    ret_q   <= IDLE;
                    deb_q   <= '0;
                    hold_q  <= '0;
                    level_q <= 1'b0;
                    press_q <= 1'b0;
                    rel_q   <= 1'b0;
                    long_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    ret_q   <= ret_d;
                    deb_q   <= deb_d;
                    hold_q  <= hold_d;
                    level_q <= level_d;
                    press_q <= press_d;
                    rel_q   <= rel_d;
                    long_q  <= long_d;
                end
            end

            assign btn_level[i]   = level_q;
            assign btn_press[i]   = press_q;
            assign btn_release[i] = rel_q;
            assign btn_long[i]    = long_q;
        end
    endgenerate

endmodule

// File: tb/tb_btn_debounce_sv.sv
// Scoreboard bench: stable-run reference model feeds an expected-event queue,
// a negedge monitor pops and compares against both polarity variants.
module tb_btn_debounce_sv;

    localparam int DEB = 4;
    localparam int LNG = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btns = 2'b00;
    logic [1:0] btns_n;
    logic [1:0] lvl_h, prs_h, rel_h, lng_h;
    logic [1:0] lvl_l, prs_l, rel_l, lng_l;

    // Active-low instance sees the complement, so it must behave identically.
    assign btns_n = ~btns;

    btn_debounce_sv #(.CLOCK_XTAL(1000), .BTN_NUM(2), .DEBOUNCE_MS(DEB),
                      .LONG_MS(LNG), .BTN_ACTIVE_HIGH(1)) u_hi (
        .clk(clk), .rst(rst), .btns(btns), .btn_level(lvl_h),
        .btn_press(prs_h), .btn_release(rel_h), .btn_long(lng_h));

    btn_debounce_sv #(.CLOCK_XTAL(1000), .BTN_NUM(2), .DEBOUNCE_MS(DEB),
                      .LONG_MS(LNG), .BTN_ACTIVE_HIGH(0)) u_lo (
        .clk(clk), .rst(rst), .btns(btns_n), .btn_level(lvl_l),
        .btn_press(prs_l), .btn_release(rel_l), .btn_long(lng_l));

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int b;
        int kind;   // 0 press, 1 release, 2 long
    } ev_t;

    ev_t        exp_q[$];
    int         cyc = 0;
    logic [1:0] exp_lvl = 2'b00;
    int         checks = 0;
    int         errors = 0;
    int         last_press[2];
    int         n_long[2];
    int         n_rel[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: a level change is accepted once the synchronised pin
    // (pin delayed two clocks) has differed from the accepted level for
    // DEB+1 consecutive clocks. Long press fires after LNG clocks of
    // uninterrupted hold following acceptance (time spent in a release
    // glitch is not counted).
    initial begin
        logic [1:0] d1, d2, prv, lv;
        int  run[2];
        int  hold[2];
        bit  ldone[2];
        d1 = 0; d2 = 0; prv = 0;
        for (int b = 0; b < 2; b++) begin run[b] = 0; hold[b] = 0; ldone[b] = 0; end
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                d1 = 0; d2 = 0; prv = 0; exp_lvl = 0;
                for (int b = 0; b < 2; b++) begin run[b] = 0; hold[b] = 0; ldone[b] = 0; end
            end else begin
                lv = d2; d2 = d1; d1 = btns;
                for (int b = 0; b < 2; b++) begin
                    if (lv[b] != exp_lvl[b]) run[b]++;
                    else                     run[b] = 0;
                    if (run[b] == DEB + 1) begin
                        run[b]     = 0;
                        exp_lvl[b] = lv[b];
                        if (lv[b]) begin
                            hold[b] = 0; ldone[b] = 0;
                            exp_q.push_back('{cyc, b, 0});
                        end else begin
                            exp_q.push_back('{cyc, b, 1});
                        end
                    end else if (exp_lvl[b] && lv[b] && prv[b] && !ldone[b]) begin
                        hold[b]++;
                        if (hold[b] == LNG) begin
                            ldone[b] = 1;
                            exp_q.push_back('{cyc, b, 2});
                        end
                    end
                end
                prv = lv;
            end
        end
    end

    // Monitor: pops the events due this cycle and compares against both DUTs.
    initial begin
        logic [1:0] ep, er, el;
        for (int b = 0; b < 2; b++) begin last_press[b] = -100; n_long[b] = 0; n_rel[b] = 0; end
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_outputs", {16'h0, lvl_h, prs_h, rel_h, lng_h, lvl_l, prs_l, rel_l, lng_l}, 32'h0);
                exp_q.delete();
            end else begin
                ep = 0; er = 0; el = 0;
                while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                    chk("missed_event", 32'(exp_q[0].kind), 32'hFF);
                    void'(exp_q.pop_front());
                end
                while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                    case (exp_q[0].kind)
                        0:       ep[exp_q[0].b] = 1'b1;
                        1:       er[exp_q[0].b] = 1'b1;
                        default: el[exp_q[0].b] = 1'b1;
                    endcase
                    void'(exp_q.pop_front());
                end
                if ((ep | er | el | prs_h | rel_h | lng_h) != 0)
                    chk("pulses_hi", {26'h0, prs_h, rel_h, lng_h}, {26'h0, ep, er, el});
                if ((ep | er | el | prs_l | rel_l | lng_l) != 0)
                    chk("pulses_lo", {26'h0, prs_l, rel_l, lng_l}, {26'h0, ep, er, el});
                chk("level_hi", {30'h0, lvl_h}, {30'h0, exp_lvl});
                chk("level_lo", {30'h0, lvl_l}, {30'h0, exp_lvl});
                for (int b = 0; b < 2; b++) begin
                    if (prs_h[b]) last_press[b] = cyc;
                    if (lng_h[b]) n_long[b]++;
                    if (rel_h[b]) n_rel[b]++;
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Watchdog: the bench is cycle-bounded, this only guards against a stall.
    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rise, nl, nr;
        #1;
        chk("reset_initial", {24'h0, lvl_h, prs_h, rel_h, lng_h}, 32'h0);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(3);

        // Clean press on button 0, with explicit latency from the first sampling edge.
        btns[0] = 1'b1; rise = cyc + 1;
        wait_cyc(10);
        chk("press_latency", 32'((last_press[0] - rise) >= 5 && (last_press[0] - rise) <= 7), 32'h1);
        btns[0] = 1'b0;
        wait_cyc(12);

        // Bounce on button 0 then settle high.
        for (int k = 0; k < 4; k++) begin
            btns[0] = (k % 2 == 0); wait_cyc(2);
        end
        btns[0] = 1'b1; wait_cyc(12);
        btns[0] = 1'b0; wait_cyc(12);

        // Long press on button 1.
        nl = n_long[1];
        btns[1] = 1'b1; wait_cyc(40);
        btns[1] = 1'b0; wait_cyc(12);
        chk("long_once", 32'(n_long[1] - nl), 32'h1);

        // Release glitch on button 0 while pressed.
        nr = n_rel[0];
        btns[0] = 1'b1; wait_cyc(10);
        btns[0] = 1'b0; wait_cyc(2);
        btns[0] = 1'b1; wait_cyc(10);
        chk("glitch_no_release", 32'(n_rel[0] - nr), 32'h0);
        btns[0] = 1'b0; wait_cyc(12);

        // Reset during a held press; pin stays high across reset.
        nr = n_rel[0];
        btns[0] = 1'b1; wait_cyc(10);
        @(posedge clk); #2; rst = 1'b1; #1;
        chk("reset_async", {24'h0, lvl_h, prs_h, rel_h, lng_h}, 32'h0);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(12);
        chk("reset_no_release", 32'(n_rel[0] - nr), 32'h0);
        btns[0] = 1'b0; wait_cyc(12);

        // Simultaneous press and long on both buttons.
        btns = 2'b11; wait_cyc(32);
        btns = 2'b00; wait_cyc(12);

        // Randomised pin activity.
        for (int s = 0; s < 80; s++) begin
            btns = 2'($urandom);
            if ($urandom_range(0, 3) == 0) wait_cyc($urandom_range(1, 5));
            else                           wait_cyc($urandom_range(4, 30));
        end

        btns = 2'b00;
        wait_cyc(20);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_debounce_sv.md
BTN_DEBOUNCE_SV -- requirements
Module: btn_debounce_sv

Interface
REQ-001 The block SHALL have parameter CLOCK_XTAL, default 27000000, meaning input clock frequency in Hz.
REQ-002 The block SHALL have parameter BTN_NUM, default 2, meaning number of push-button inputs.
REQ-003 The block SHALL have parameter DEBOUNCE_MS, default 10, meaning the stable time in ms needed to accept a level change.
REQ-004 The block SHALL have parameter LONG_MS, default 1000, meaning the hold time in ms, counted from the accepted press, that qualifies as a long press.
REQ-005 The block SHALL have parameter BTN_ACTIVE_HIGH, default 1, meaning the button is pressed when the pin is 1; when 0, pressed is when the pin is 0.
REQ-006 The block SHALL have port clk, input, width 1, the single system clock.
REQ-007 The block SHALL have port rst, input, width 1; reset is asynchronous and active-high.
REQ-008 The block SHALL have port btns, input, width BTN_NUM, raw asynchronous button pins.
REQ-009 The block SHALL have port btn_level, output, width BTN_NUM, debounced pressed state (1 = pressed).
REQ-010 The block SHALL have port btn_press, output, width BTN_NUM, a 1-cycle pulse when a press is accepted.
REQ-011 The block SHALL have port btn_release, output, width BTN_NUM, a 1-cycle pulse when a release is accepted.
REQ-012 The block SHALL have port btn_long, output, width BTN_NUM, a 1-cycle pulse on long-press qualification.

Function
REQ-013 Each btns bit SHALL pass through a 2-flop synchronizer, then be normalized to pressed = 1 according to BTN_ACTIVE_HIGH.
REQ-014 A shared ms tick SHALL pulse for 1 clk every CLOCK_XTAL/1000 cycles; its counter width is $clog2(CLOCK_XTAL/1000); when CLOCK_XTAL/1000 = 1, the tick is high every cycle.
REQ-015 Each button SHALL run an independent FSM with states IDLE, PRESS_WAIT, PRESSED, LONG_HELD and RELEASE_WAIT.
REQ-016 FSM transitions:
- IDLE -> PRESS_WAIT when the synced level is 1; clear the debounce counter.
- PRESS_WAIT -> IDLE when the synced level is 0 on any cycle (a bounce).
- PRESS_WAIT -> PRESSED on the tick where the counter reaches DEBOUNCE_MS.
REQ-017 On entry to PRESSED, the FSM SHALL set btn_level to 1, pulse btn_press, and clear the hold counter.
REQ-018 In PRESSED, the hold counter SHALL increment per tick; on reaching LONG_MS the FSM SHALL move to LONG_HELD and pulse btn_long exactly once.
REQ-019 From PRESSED or LONG_HELD, a synced level of 0 SHALL move the FSM to RELEASE_WAIT, clear the debounce counter, and remember the originating state.
REQ-020 From RELEASE_WAIT, a synced level of 1 on any cycle SHALL return the FSM to the remembered state.
- The hold counter SHALL not reset.
- No pulses SHALL be emitted.
REQ-021 From RELEASE_WAIT, when the counter reaches DEBOUNCE_MS the FSM SHALL move to IDLE, set btn_level to 0, and pulse btn_release.
REQ-022 The debounce and hold counters SHALL saturate and never wrap.
- Debounce counter width: $clog2(DEBOUNCE_MS+1).
- Hold counter width: $clog2(LONG_MS+1).
REQ-023 At most one of btn_press, btn_release or btn_long SHALL be high per button per cycle.
REQ-024 Buttons SHALL NOT interact; simultaneous presses on several bits SHALL produce simultaneous pulses.
REQ-025 A press held indefinitely SHALL produce exactly one btn_long and no further pulses until release.

Reset
REQ-026 While rst = 1, all outputs SHALL be 0, FSMs SHALL be in IDLE, counters SHALL be 0, and synchronizer flops SHALL hold the not-pressed level.
REQ-027 A button held through reset deassertion SHALL be treated as a new press requiring a full DEBOUNCE_MS.
- No btn_release SHALL be emitted for a press cut off by reset.

Structure
REQ-028 Package btn_pkg SHALL hold the FSM state enum btn_state_t and a function ms_to_cycles.
REQ-029 Sub-module btn_tick_gen SHALL generate the ms tick; it SHALL be instantiated once and shared by all button FSMs, which are built with a generate loop.

Verification
REQ-030 Benches SHALL use CLOCK_XTAL=1000, DEBOUNCE_MS=4, LONG_MS=20 and BTN_NUM=2, giving a tick every cycle.
REQ-031 Clean press: raise btns[0] and hold for 10 cycles -> btn_press[0] pulses once, 6 cycles after the edge (+/-1); btn_level[0] = 1 afterwards.
REQ-032 Bounce: toggle btns[0] 1,0,1,0 every 2 cycles, then hold 1 -> no pulse during the toggling; a single btn_press[0] about 6 cycles after the final rise.
REQ-033 Long press: hold btns[1] for 40 cycles -> btn_press[1] then btn_long[1] 20 cycles later; exactly one btn_long[1]; btn_release[1] about 6 cycles after the pin falls.
REQ-034 Release glitch: while pressed, drop btns[0] for 2 cycles then restore -> no btn_release[0]; btn_level[0] stays 1.
REQ-035 Reset mid-press: assert rst during PRESSED with the pin held -> outputs go to 0 immediately; after rst falls, a new btn_press[0] arrives about 6 cycles later and no btn_release is emitted.
REQ-036 Active-low polarity: with BTN_ACTIVE_HIGH=0, pulling btns[0] to 0 -> btn_press[0] about 6 cycles later, and idle-high pins produce no pulses.
